prog_mem_loadable: RTL and testbench

- Parametrised program store for the multi-module CPU tests.
- Behaves as the core's instruction memory: synchronous, registered read port with a request/valid handshake.
- Adds a streaming load port, so testbenches and boot logic can write a program at any base address.
- After reset, a clear sequence zeroes the whole store. It optionally pre-loads a built-in boot program.

---
 rtl/prog_mem_loadable.sv | 140 ++++++++++++++
 tb/tb_prog_mem_loadable.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loadable.sv
// Loadable program store: registered read port, streaming load port, and a clear sequence after reset.
// Optional boot image in the clear sequence is enabled with `define PROG_BOOT_IMAGE_EN.
module prog_mem_loadable #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_err,
    output logic          busy
);

    localparam int DEPTH = 2**AW;

`ifdef PROG_BOOT_IMAGE_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] wr_ptr;
    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          rd_accept;

    function automatic logic [DW-1:0] clear_word(input logic [AW-1:0] a);
        logic [15:0]   w;
        logic [DW-1:0] r;
        w = 16'h0000;
        if (BOOT_EN) begin
            case (int'(a))
                0:       w = 16'h1005;
                1:       w = 16'h2007;
                2:       w = 16'h300F;
                3:       w = 16'h20FD;
                4:       w = 16'h5006;
                5:       w = 16'h1155;
                6:       w = 16'hF000;
                default: w = 16'h0000;
            endcase
        end
        r       = '0;
        r[15:0] = w;
        return r;
    endfunction

    assign rd_ready  = (state != S_CLEAR);
    assign ld_ready  = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign rd_accept = rd_req && rd_ready;

    // Single write port shared by the clear sweep and the load stream.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = clear_word(clr_ptr);
        if (state == S_CLEAR) begin
            mem_we = 1'b1;
        end else if (state == S_LOAD && ld_valid) begin
            mem_we    = 1'b1;
            mem_waddr = wr_ptr;
            mem_wdata = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Read sees the pre-write contents, giving read-first behaviour on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept)
                rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            wr_ptr  <= '0;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (ld_start) begin
                        wr_ptr <= ld_base;
                        ld_err <= 1'b0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if ((&wr_ptr) && !ld_last)
                            ld_err <= 1'b1;
                        if (ld_last) begin
                            ld_done <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Randomised and directed bench for prog_mem_loadable against a behavioural model of the store.
// Build with +define+PROG_BOOT_IMAGE_EN on both files to check the boot image variant.
module tb_prog_mem_loadable;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 256;

`ifdef PROG_BOOT_IMAGE_EN
    localparam logic [15:0] EXP_A00 = 16'h1005;
    localparam logic [15:0] EXP_A06 = 16'hF000;
`else
    localparam logic [15:0] EXP_A00 = 16'h0000;
    localparam logic [15:0] EXP_A06 = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: phase 0 = clearing, 1 = idle, 2 = loading.
    int m_mem [DEPTH];
    int m_phase;
    int m_clr_cnt;
    int m_ptr;
    int m_err;
    int e_valid;
    int e_data;
    int e_done;

    prog_mem_loadable #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int boot_value(input int a);
`ifdef PROG_BOOT_IMAGE_EN
        int img [7] = '{32'h1005, 32'h2007, 32'h300F, 32'h20FD, 32'h5006, 32'h1155, 32'hF000};
        if (a < 7) return img[a];
`endif
        return a * 0;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_clr_cnt = 0;
        m_ptr     = 0;
        m_err     = 0;
        e_valid   = 0;
        e_data    = 0;
        e_done    = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int old_phase;
        old_phase = m_phase;
        if (rd_req && old_phase != 0) begin
            e_valid = 1;
            e_data  = m_mem[rd_addr];
        end else begin
            e_valid = 0;
        end
        e_done = 0;
        if (old_phase == 0) begin
            m_mem[m_clr_cnt] = boot_value(m_clr_cnt);
            m_clr_cnt++;
            if (m_clr_cnt == DEPTH) m_phase = 1;
        end else if (old_phase == 1) begin
            if (ld_start) begin
                m_ptr   = ld_base;
                m_err   = 0;
                m_phase = 2;
            end
        end else if (ld_valid) begin
            m_mem[m_ptr] = ld_data;
            if (m_ptr == DEPTH - 1 && !ld_last) m_err = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (ld_last) begin
                m_phase = 1;
                e_done  = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("rd_valid", rd_valid, e_valid);
        check_eq("rd_data",  rd_data,  e_data);
        check_eq("ld_done",  ld_done,  e_done);
        check_eq("ld_err",   ld_err,   m_err);
        check_eq("busy",     busy,     m_phase != 1);
        check_eq("rd_ready", rd_ready, m_phase != 0);
        check_eq("ld_ready", ld_ready, m_phase == 2);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_req   = 1'b0;
        rd_addr  = '0;
        ld_start = 1'b0;
        ld_base  = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic run_clear();
        int n;
        n = 0;
        idle_inputs();
        rd_req = 1'b1;
        do begin
            step();
            n++;
        end while (busy && n < 1000);
        check_eq("clear_len", n, DEPTH);
        rd_req = 1'b0;
    endtask

    task automatic read_at(input int a, input logic [15:0] exp, input string tag);
        idle_inputs();
        rd_req  = 1'b1;
        rd_addr = AW'(a);
        step();
        rd_req  = 1'b0;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        idle_inputs();
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
    endtask

    task automatic start_load(input int base);
        idle_inputs();
        ld_start = 1'b1;
        ld_base  = AW'(base);
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        run_clear();

        read_at(8'h00, EXP_A00, "clr_rd00");
        read_at(8'h06, EXP_A06, "clr_rd06");
        read_at(8'hFF, 16'h0000, "clr_rdFF");

        start_load(8'h10);
        load_word(16'hA001, 1'b0);
        idle_inputs();
        step();
        load_word(16'hA002, 1'b0);
        load_word(16'hA003, 1'b1);
        check_eq("ld_done_pulse", ld_done, 1'b1);
        idle_inputs();
        step();
        check_eq("ld_done_clear", ld_done, 1'b0);
        read_at(8'h10, 16'hA001, "burst_rd10");
        read_at(8'h11, 16'hA002, "burst_rd11");
        read_at(8'h12, 16'hA003, "burst_rd12");
        read_at(8'h13, 16'h0000, "burst_rd13");

        start_load(8'hFE);
        load_word(16'h00B0, 1'b0);
        load_word(16'h00B1, 1'b0);
        load_word(16'h00B2, 1'b1);
        check_eq("wrap_err", ld_err, 1'b1);
        read_at(8'hFE, 16'h00B0, "wrap_rdFE");
        read_at(8'hFF, 16'h00B1, "wrap_rdFF");
        read_at(8'h00, 16'h00B2, "wrap_rd00");

        start_load(8'h20);
        check_eq("err_cleared", ld_err, 1'b0);
        idle_inputs();
        ld_valid = 1'b1;
        ld_data  = 16'hC0DE;
        ld_last  = 1'b1;
        rd_req   = 1'b1;
        rd_addr  = 8'h20;
        step();
        check_eq("collide_old", rd_data, 16'h0000);
        read_at(8'h20, 16'hC0DE, "collide_new");

        for (int a = 0; a < 4; a++) begin
            idle_inputs();
            rd_req  = 1'b1;
            rd_addr = AW'(a);
            step();
            check_eq("stream_valid", rd_valid, 1'b1);
        end

        for (int c = 0; c < 1500; c++) begin
            rd_req   = ($urandom_range(0, 1) == 1);
            rd_addr  = AW'($urandom);
            ld_start = ($urandom_range(0, 9) == 0);
            ld_base  = AW'($urandom);
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_data  = DW'($urandom);
            ld_last  = ($urandom_range(0, 7) == 0);
            step();
        end

        load_word(16'h0000, 1'b1);
        start_load(8'h40);
        load_word(16'hD001, 1'b0);
        load_word(16'hD002, 1'b0);
        do_reset();
        run_clear();
        read_at(8'h40, 16'h0000, "rst_rd40");
        read_at(8'h41, 16'h0000, "rst_rd41");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
